// File: rtl/tnn_pkg.sv
// tnn_pkg: shared types and constants for the TNN feature packer
package tnn_pkg;
    localparam int N_FEAT = 5;
    localparam int CODE_W = 2;
    typedef logic [CODE_W-1:0] code_t;
    typedef enum logic [1:0] {COLLECT, DROP, EVAL, RESULT} state_t;
    localparam logic [1:0] THR_IDX0 = 2'd0;
    localparam logic [1:0] THR_IDX1 = 2'd1;
    localparam logic [1:0] THR_IDX2 = 2'd2;
    localparam logic [1:0] THR_NONE = 2'd3;
endpackage

// File: rtl/tnn_quantizer.sv
// tnn_quantizer: maps a raw feature to a 2-bit code by counting thresholds met
module tnn_quantizer
    import tnn_pkg::*;
#(
    parameter int FEAT_W = 8
) (
    input  logic [FEAT_W-1:0] data,
    input  logic [FEAT_W-1:0] thr0,
    input  logic [FEAT_W-1:0] thr1,
    input  logic [FEAT_W-1:0] thr2,
    output code_t             code
);
    // Count form keeps unordered threshold sets well defined
    assign code = {1'b0, data >= thr0} + {1'b0, data >= thr1} + {1'b0, data >= thr2};
endmodule

// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer: quantizes a feature stream into the classifier vector and returns its class
module tnn_feature_packer
    import tnn_pkg::*;
#(
    parameter int FEAT_W   = 8,
    parameter int CNT_W    = 16,
    parameter int THR0_RST = 64,
    parameter int THR1_RST = 128,
    parameter int THR2_RST = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [FEAT_W-1:0] feat_data,
    input  logic              feat_last,
    input  logic              thr_we,
    input  logic [1:0]        thr_sel,
    input  logic [FEAT_W-1:0] thr_data,
    output logic [1:0]        cls_a,
    output logic [1:0]        cls_b,
    output logic [1:0]        cls_c,
    output logic [1:0]        cls_d,
    output logic [1:0]        cls_e,
    input  logic              cls_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_class,
    output logic              res_err,
    output logic [CNT_W-1:0]  res_count
);
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    code_t             slot_q [N_FEAT];
    code_t             slot_d [N_FEAT];
    logic [FEAT_W-1:0] thr_q [3];
    logic [FEAT_W-1:0] thr_d [3];
    logic              err_q, err_d;
    logic              res_valid_q, res_valid_d;
    logic              res_class_q, res_class_d;
    logic              res_err_q, res_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    code_t             code;

    tnn_quantizer #(.FEAT_W(FEAT_W)) u_quant (
        .data (feat_data),
        .thr0 (thr_q[0]),
        .thr1 (thr_q[1]),
        .thr2 (thr_q[2]),
        .code (code)
    );

    assign feat_ready = (state_q == COLLECT) || (state_q == DROP);
    assign cls_a      = slot_q[0];
    assign cls_b      = slot_q[1];
    assign cls_c      = slot_q[2];
    assign cls_d      = slot_q[3];
    assign cls_e      = slot_q[4];
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_err    = res_err_q;
    assign res_count  = cnt_q;

    // Threshold writes land at the edge, so the accepting feature still sees the old set
    always_comb begin
        thr_d = thr_q;
        if (thr_we && thr_sel != THR_NONE) thr_d[thr_sel] = thr_data;
    end

    // Next-state and datapath updates for the packing FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_err_d   = res_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            COLLECT: if (feat_valid) begin
                slot_d[idx_q] = code;
                if (feat_last) begin
                    for (int j = 0; j < N_FEAT; j++)
                        if (j > int'(idx_q)) slot_d[j] = '0;
                    err_d   = (idx_q != 3'(N_FEAT - 1));
                    state_d = EVAL;
                end else if (idx_q == 3'(N_FEAT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DROP;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DROP: if (feat_valid && feat_last) state_d = EVAL;
            EVAL: begin
                res_class_d = cls_out;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: if (res_ready) begin
                res_valid_d = 1'b0;
                cnt_d       = cnt_q + CNT_W'(1);
                idx_d       = '0;
                state_d     = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            for (int j = 0; j < N_FEAT; j++) slot_q[j] <= '0;
            thr_q[0]    <= FEAT_W'(THR0_RST);
            thr_q[1]    <= FEAT_W'(THR1_RST);
            thr_q[2]    <= FEAT_W'(THR2_RST);
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= 1'b0;
            res_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            thr_q       <= thr_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_err_q   <= res_err_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_tnn_feature_packer.sv
// tb_tnn_feature_packer: directed self-checking bench for the feature packer
module tb_tnn_feature_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        feat_valid = 1'b0;
    logic        feat_ready;
    logic [7:0]  feat_data = '0;
    logic        feat_last = 1'b0;
    logic        thr_we = 1'b0;
    logic [1:0]  thr_sel = '0;
    logic [7:0]  thr_data = '0;
    logic [1:0]  cls_a, cls_b, cls_c, cls_d, cls_e;
    logic        cls_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_class;
    logic        res_err;
    logic [15:0] res_count;
    int          checks = 0;
    int          errors = 0;

    tnn_feature_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .thr_we     (thr_we),
        .thr_sel    (thr_sel),
        .thr_data   (thr_data),
        .cls_a      (cls_a),
        .cls_b      (cls_b),
        .cls_c      (cls_c),
        .cls_d      (cls_d),
        .cls_e      (cls_e),
        .cls_out    (cls_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_err    (res_err),
        .res_count  (res_count)
    );

    // Classifier stand-in: class is the high bit of the first code
    assign cls_out = cls_a[1];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = l;
        while (!feat_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", {31'd0, feat_ready}, 32'd1);
        @(posedge clk); #1;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send5(input logic [7:0] a, b, c, d, e);
        send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b0); send(e, 1'b1);
    endtask

    task automatic get_result(input string tag, input logic cls, input logic err, input logic [15:0] cnt);
        int n = 0;
        while (!res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_class"}, {31'd0, res_class}, {31'd0, cls});
        chk({tag, "_err"}, {31'd0, res_err}, {31'd0, err});
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_done"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_count"}, {16'd0, res_count}, {16'd0, cnt});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_count", {16'd0, res_count}, 32'd0);
        chk("rst_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, 32'd0);
        chk("rst_class_err", {30'd0, res_class, res_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, feat_ready}, 32'd1);

        send5(8'd10, 8'd70, 8'd130, 8'd200, 8'd255);
        chk("s1_eval_valid", {31'd0, res_valid}, 32'd0);
        chk("s1_eval_ready", {31'd0, feat_ready}, 32'd0);
        chk("s1_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, {22'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3});
        @(posedge clk); #1;
        chk("s1_latency", {31'd0, res_valid}, 32'd1);
        get_result("s1", 1'b0, 1'b0, 16'd1);

        send5(8'd200, 8'd0, 8'd0, 8'd0, 8'd0);
        get_result("s2", 1'b1, 1'b0, 16'd2);

        send5(8'd100, 8'd0, 8'd0, 8'd200, 8'd200);
        chk("s3_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, {22'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3});
        get_result("s3", 1'b0, 1'b0, 16'd3);

        send(8'd150, 1'b0); send(8'd150, 1'b0); send(8'd150, 1'b1);
        chk("short_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, {22'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0});
        get_result("short", 1'b1, 1'b1, 16'd4);

        send(8'd255, 1'b0); send(8'd64, 1'b0); send(8'd128, 1'b0); send(8'd192, 1'b0);
        send(8'd0, 1'b0); send(8'd255, 1'b0); send(8'd255, 1'b1);
        chk("long_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, {22'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0});
        get_result("long", 1'b1, 1'b1, 16'd5);
        send5(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        get_result("after_long", 1'b0, 1'b0, 16'd6);

        thr_we = 1'b1; thr_sel = 2'd1; thr_data = 8'd10;
        send(8'd50, 1'b0);
        thr_we = 1'b0;
        send(8'd50, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
        chk("thr_cls", {28'd0, cls_a, cls_b}, {28'd0, 2'd0, 2'd1});
        get_result("thr", 1'b0, 1'b0, 16'd7);

        thr_we = 1'b1; thr_sel = 2'd3; thr_data = 8'd0;
        @(posedge clk); #1;
        thr_we = 1'b0;
        send5(8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
        chk("sel3_cls", {22'd0, cls_a, cls_b, cls_c, cls_d, cls_e}, {22'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
        get_result("sel3", 1'b0, 1'b0, 16'd8);

        send5(8'd200, 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        feat_valid = 1'b1; feat_data = 8'd0; feat_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold", {28'd0, res_valid, res_class, res_err, feat_ready}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        chk("hold_cls_a", {30'd0, cls_a}, 32'd3);
        feat_valid = 1'b0; feat_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, res_valid}, 32'd0);
        chk("async_count", {16'd0, res_count}, 32'd0);
        chk("async_cls_a", {30'd0, cls_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, feat_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
